// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcode and funct codes used by the ALU,
// the control unit and the instruction decode logic, plus the shifter kind.
package mips_pkg;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes, instruction[5:0]
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // Shift flavour selected by the ALU decode
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_kind_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: logical left, logical right, arithmetic right.
module alu_shifter
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       shamt_i,
  input  shift_kind_e      kind_i,
  output logic [WIDTH-1:0] res_o
);

  // Select the shift flavour; the unused encoding falls back to a left shift
  always_comb begin
    res_o = b_i << shamt_i;
    case (kind_i)
      SH_SLL:  res_o = b_i << shamt_i;
      SH_SRL:  res_o = b_i >> shamt_i;
      SH_SRA:  res_o = $unsigned($signed(b_i) >>> shamt_i);
      default: res_o = b_i << shamt_i;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage MIPS ALU. Decodes opcode/func/sa directly and registers a
// 32-bit result and a branch-condition flag (beq/bne only).
// Optional feature: define ALU_OVERFLOW_EN to add a registered signed
// overflow output for add/sub/addi.
module alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       func,
  input  logic [5:0]       opcode,
  input  logic [4:0]       sa,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic [WIDTH-1:0] sum, diff, zext_b, sh_res;
  logic [4:0]       sh_amt;
  shift_kind_e      sh_kind;

  assign sum    = a + b;
  assign diff   = a - b;
  assign zext_b = {16'b0, b[15:0]};

  // Variable shifts take their amount from a[4:0]; func[1:0] picks the kind
  always_comb begin
    sh_amt  = func[2] ? a[4:0] : sa;
    sh_kind = SH_SLL;
    case (func[1:0])
      2'b10:   sh_kind = SH_SRL;
      2'b11:   sh_kind = SH_SRA;
      default: sh_kind = SH_SLL;
    endcase
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .b_i     (b),
    .shamt_i (sh_amt),
    .kind_i  (sh_kind),
    .res_o   (sh_res)
  );

  // Main decode: result and branch condition for the instruction in EX
  always_comb begin
    result_d = '0;
    zero_d   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          F_ADD, F_ADDU:  result_d = sum;
          F_SUB, F_SUBU:  result_d = diff;
          F_AND:          result_d = a & b;
          F_OR:           result_d = a | b;
          F_XOR:          result_d = a ^ b;
          F_NOR:          result_d = ~(a | b);
          F_SLT:          result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          F_SLTU:         result_d = {{(WIDTH-1){1'b0}}, (a < b)};
          F_SLL, F_SRL, F_SRA,
          F_SLLV, F_SRLV, F_SRAV: result_d = sh_res;
          F_JR:           result_d = a;
          default:        result_d = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: result_d = sum;
      OP_SLTI:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTIU: result_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_ANDI:  result_d = a & zext_b;
      OP_ORI:   result_d = a | zext_b;
      OP_XORI:  result_d = a ^ zext_b;
      OP_LUI:   result_d = {b[15:0], 16'b0};
      OP_BEQ: begin
        result_d = diff;
        zero_d   = (a == b);
      end
      OP_BNE: begin
        result_d = diff;
        zero_d   = (a != b);
      end
      default:  result_d = '0;
    endcase
  end

  // Output register feeding EX/MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result    = result_q;
  assign zero_flag = zero_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_d, ovf_q;
  logic ovf_add, ovf_sub;

  // Signed overflow: operands of matching (add) or differing (sub) sign whose
  // result sign departs from a
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Only the trapping arithmetic forms report overflow
  always_comb begin
    ovf_d = 1'b0;
    if (opcode == OP_RTYPE && func == F_ADD) ovf_d = ovf_add;
    if (opcode == OP_RTYPE && func == F_SUB) ovf_d = ovf_sub;
    if (opcode == OP_ADDI)                   ovf_d = ovf_add;
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the execute-stage ALU.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic [5:0]  func, opcode;
  logic [4:0]  sa;
  logic [31:0] result;
  logic        zero_flag;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Expected {overflow, zero_flag, result}
  logic [33:0] exp_q[$];

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .func      (func),
    .opcode    (opcode),
    .sa        (sa),
`ifdef ALU_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .result    (result),
    .zero_flag (zero_flag)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Driver: called at a negedge; applies operands, lets the posedge capture
  // them, then checks at the following negedge against the scoreboard.
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sv,
                      input logic [31:0] e_res, input logic e_zf, input logic e_ov);
    logic [33:0] e;
    opcode = op; func = fn; a = av; b = bv; sa = sv;
    exp_q.push_back({e_ov, e_zf, e_res});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check32({tag, ".result"}, result, e[31:0]);
    check1({tag, ".zero"}, zero_flag, e[32]);
`ifdef ALU_OVERFLOW_EN
    check1({tag, ".ovf"}, overflow, e[33]);
`endif
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; a = '0; b = '0; func = '0; opcode = '0; sa = '0;
    #1;
    check32("reset.result", result, 32'h0);
    check1("reset.zero", zero_flag, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type arithmetic
    step("add",   6'b000000, 6'b100000, 32'd7, 32'd5, 5'd0, 32'd12, 1'b0, 1'b0);
    step("sub",   6'b000000, 6'b100010, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    step("addu",  6'b000000, 6'b100001, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1, 1'b0, 1'b0);
    step("subu",  6'b000000, 6'b100011, 32'd100, 32'd1, 5'd0, 32'd99, 1'b0, 1'b0);
    step("slt",   6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0);
    step("sltu",  6'b000000, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b0, 1'b0);
    // Logic
    step("and",   6'b000000, 6'b100100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F, 1'b0, 1'b0);
    step("or",    6'b000000, 6'b100101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFFF0_0FFF, 1'b0, 1'b0);
    step("xor",   6'b000000, 6'b100110, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFF00_0FF0, 1'b0, 1'b0);
    step("nor",   6'b000000, 6'b100111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h000F_F000, 1'b0, 1'b0);
    // Shifts
    step("sll",   6'b000000, 6'b000000, 32'd0, 32'h8000_0000, 5'd4, 32'h0, 1'b0, 1'b0);
    step("srl",   6'b000000, 6'b000010, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0);
    step("sra",   6'b000000, 6'b000011, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0);
    step("srav",  6'b000000, 6'b000111, 32'd31, 32'h8000_0000, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step("sllv",  6'b000000, 6'b000100, 32'd4, 32'd1, 5'd9, 32'd16, 1'b0, 1'b0);
    step("srlv",  6'b000000, 6'b000110, 32'd8, 32'h8000_0000, 5'd1, 32'h0080_0000, 1'b0, 1'b0);
    step("jr",    6'b000000, 6'b001000, 32'hDEAD_BEEF, 32'd3, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step("badfn", 6'b000000, 6'b111111, 32'd7, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0);
    // I-type
    step("addi",  6'b001000, 6'b000000, 32'd10, 32'hFFFF_FFFF, 5'd0, 32'd9, 1'b0, 1'b0);
    step("lw",    6'b100011, 6'b000000, 32'h1000, 32'h0000_0010, 5'd0, 32'h1010, 1'b0, 1'b0);
    step("slti",  6'b001010, 6'b000000, 32'hFFFF_FFFE, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0);
    step("sltiu", 6'b001011, 6'b000000, 32'hFFFF_FFFE, 32'd1, 5'd0, 32'd0, 1'b0, 1'b0);
    step("ori",   6'b001101, 6'b000000, 32'd0, 32'hFFFF_8001, 5'd0, 32'h0000_8001, 1'b0, 1'b0);
    step("andi",  6'b001100, 6'b000000, 32'hFFFF_FFFF, 32'hFFFF_00F0, 5'd0, 32'h0000_00F0, 1'b0, 1'b0);
    step("xori",  6'b001110, 6'b000000, 32'h0000_FFFF, 32'hFFFF_00FF, 5'd0, 32'h0000_FF00, 1'b0, 1'b0);
    step("lui",   6'b001111, 6'b000000, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 1'b0);
    step("j",     6'b000010, 6'b100000, 32'd7, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0);
    step("badop", 6'b111111, 6'b100000, 32'd7, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0);
    // Branches
    step("beq_eq",  6'b000100, 6'b000000, 32'd9, 32'd9, 5'd0, 32'h0, 1'b1, 1'b0);
    step("bne_eq",  6'b000101, 6'b000000, 32'd9, 32'd9, 5'd0, 32'h0, 1'b0, 1'b0);
    step("bne_ne",  6'b000101, 6'b000000, 32'd9, 32'd3, 5'd0, 32'd6, 1'b1, 1'b0);
    step("beq_ne",  6'b000100, 6'b000000, 32'd9, 32'd3, 5'd0, 32'd6, 1'b0, 1'b0);
    // Overflow cases (flag only visible with the optional port)
    step("add_ovf",  6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b1);
    step("addu_ovf", 6'b000000, 6'b100001, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b0);
    step("sub_ovf",  6'b000000, 6'b100010, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step("addi_ovf", 6'b001000, 6'b000000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Operands changing after the capture edge must not disturb the output
    step("hold", 6'b000100, 6'b000000, 32'd4, 32'd4, 5'd0, 32'h0, 1'b1, 1'b0);
    a = 32'd123; b = 32'd7; opcode = 6'b000000; func = 6'b100000;
    #2;
    check32("hold.result", result, 32'h0);
    check1("hold.zero", zero_flag, 1'b1);

    // Asynchronous reset mid-operation, away from any clock edge
    rst_n = 1'b0;
    #1;
    check32("async_rst.result", result, 32'h0);
    check1("async_rst.zero", zero_flag, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 6'b000000, 6'b100000, 32'd7, 32'd5, 5'd0, 32'd12, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
